// File: rtl/register_file_pkg.sv
`default_nettype none
// ============================================================================
// Module      : register_file_pkg
// Description : Shared sizing constants for the ARM-style register file.
// Revision    : 1.0 - initial release
// ============================================================================
package register_file_pkg;

  localparam int C_ADDR_WIDTH = 4;
  localparam int C_DATA_WIDTH = 32;
  localparam int C_NUM_REGS   = 16;
  localparam int C_PC_INDEX   = 15;

endpackage : register_file_pkg
`default_nettype wire

// File: rtl/register_file_reg32.sv
`default_nettype none
// ============================================================================
// Module      : register_file_reg32
// Description : One storage register with load enable and synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file_reg32
  import register_file_pkg::*;
#(
  parameter int WIDTH = C_DATA_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LE,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] r_data_q;
  logic [WIDTH-1:0] w_data_d;

  always_comb begin
    w_data_d = r_data_q;
    if (LE) begin
      w_data_d = D;
    end
  end

  // Clear wins over load so a reset edge always leaves the register at zero.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_data_q <= '0;
    end else begin
      r_data_q <= w_data_d;
    end
  end

  assign Q = r_data_q;

endmodule : register_file_reg32
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module      : register_file
// Description : 16 x 32 register file, three async read ports, one write port;
//               entry 15 reads back the externally supplied program counter.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file
  import register_file_pkg::*;
#(
  parameter int ADDR_WIDTH = C_ADDR_WIDTH,
  parameter int DATA_WIDTH = C_DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  LE,
  input  logic [ADDR_WIDTH-1:0] RW,
  input  logic [DATA_WIDTH-1:0] PW,
  input  logic [ADDR_WIDTH-1:0] RA,
  input  logic [ADDR_WIDTH-1:0] RB,
  input  logic [ADDR_WIDTH-1:0] RC,
  input  logic [DATA_WIDTH-1:0] PROGCOUNT,
  output logic [DATA_WIDTH-1:0] PA,
  output logic [DATA_WIDTH-1:0] PB,
  output logic [DATA_WIDTH-1:0] PC
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;
  localparam int PC_INDEX = NUM_REGS - 1;

  logic [DATA_WIDTH-1:0] w_rd [NUM_REGS];

  // The PC slot has no storage, so a write addressed to it decodes to nothing.
  for (genvar i = 0; i < PC_INDEX; i++) begin : g_reg
    logic w_we;
    assign w_we = LE && (RW == ADDR_WIDTH'(i));

    register_file_reg32 #(
      .WIDTH (DATA_WIDTH)
    ) u_reg (
      .CLK (CLK),
      .RST (RST),
      .LE  (w_we),
      .D   (PW),
      .Q   (w_rd[i])
    );
  end

  assign w_rd[PC_INDEX] = PROGCOUNT;

  assign PA = w_rd[RA];
  assign PB = w_rd[RB];
  assign PC = w_rd[RC];

endmodule : register_file
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_file
// Description : Directed self-checking bench for register_file.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        LE = 1'b0;
  logic [3:0]  RW = '0;
  logic [31:0] PW = '0;
  logic [3:0]  RA = '0;
  logic [3:0]  RB = '0;
  logic [3:0]  RC = '0;
  logic [31:0] PROGCOUNT = '0;
  logic [31:0] PA;
  logic [31:0] PB;
  logic [31:0] PC;

  int checks = 0;
  int errors = 0;

  register_file dut (
    .CLK       (CLK),
    .RST       (RST),
    .LE        (LE),
    .RW        (RW),
    .PW        (PW),
    .RA        (RA),
    .RB        (RB),
    .RC        (RC),
    .PROGCOUNT (PROGCOUNT),
    .PA        (PA),
    .PB        (PB),
    .PC        (PC)
  );

  always #2 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    PROGCOUNT = 32'd32;
    RST = 1'b1; LE = 1'b1; RW = 4'd3; PW = 32'd99;
    tick();
    RST = 1'b0; LE = 1'b0;
    for (int i = 0; i < 15; i++) begin
      RA = 4'(i);
      #1;
      checks++;
      if (PA !== 32'd0) begin
        errors++;
        $display("FAIL reset_R%0d got %0d expected 0", i, PA);
      end
    end
    RA = 4'd15;
    #1;
    checks++;
    if (PA !== 32'd32) begin
      errors++;
      $display("FAIL reset_R15 got %0d expected 32", PA);
    end
  endtask

  task automatic test_seq_fill();
    logic [31:0] exp_b;
    logic [31:0] exp_c;
    int b;
    int c;
    LE = 1'b1;
    for (int k = 0; k < 15; k++) begin
      RW = 4'(k); RA = 4'(k);
      b = (15 + k) % 16; c = (14 + k) % 16;
      RB = 4'(b); RC = 4'(c);
      PW = 32'(20 + k);
      tick();
      // After writing R0..Rk, Rn holds 20+n for n<=k and 0 otherwise.
      exp_b = (b == 15) ? 32'd32 : ((b <= k) ? 32'(20 + b) : 32'd0);
      exp_c = (c == 15) ? 32'd32 : ((c <= k) ? 32'(20 + c) : 32'd0);
      checks++;
      if (PA !== 32'(20 + k)) begin
        errors++;
        $display("FAIL fill_PA k=%0d got %0d expected %0d", k, PA, 20 + k);
      end
      checks++;
      if (PB !== exp_b) begin
        errors++;
        $display("FAIL fill_PB k=%0d got %0d expected %0d", k, PB, exp_b);
      end
      checks++;
      if (PC !== exp_c) begin
        errors++;
        $display("FAIL fill_PC k=%0d got %0d expected %0d", k, PC, exp_c);
      end
    end
  endtask

  task automatic test_r15_write();
    LE = 1'b1; RW = 4'd15; PW = 32'd35;
    tick();
    LE = 1'b0;
    for (int i = 0; i < 15; i++) begin
      RA = 4'(i);
      #1;
      checks++;
      if (PA !== 32'(20 + i)) begin
        errors++;
        $display("FAIL r15w_R%0d got %0d expected %0d", i, PA, 20 + i);
      end
    end
    RA = 4'd15; RB = 4'd15; RC = 4'd0;
    #1;
    checks++;
    if (PA !== 32'd32) begin
      errors++;
      $display("FAIL r15w_PA got %0d expected 32", PA);
    end
    PROGCOUNT = 32'd36;
    #1;
    checks++;
    if (PA !== 32'd36) begin
      errors++;
      $display("FAIL pc_follow_PA got %0d expected 36", PA);
    end
    checks++;
    if (PB !== 32'd36) begin
      errors++;
      $display("FAIL pc_follow_PB got %0d expected 36", PB);
    end
  endtask

  task automatic test_le_low();
    LE = 1'b1; RW = 4'd5; PW = 32'd7;
    tick();
    LE = 1'b0; PW = 32'hFFFF_FFFF;
    tick(); tick(); tick();
    RA = 4'd5; RB = 4'd6;
    #1;
    checks++;
    if (PA !== 32'd7) begin
      errors++;
      $display("FAIL le_low_R5 got %0d expected 7", PA);
    end
    checks++;
    if (PB !== 32'd26) begin
      errors++;
      $display("FAIL le_low_R6 got %0d expected 26", PB);
    end
  endtask

  task automatic test_read_before_write();
    LE = 1'b1; RW = 4'd2; PW = 32'd10;
    tick();
    RA = 4'd2; RW = 4'd2; PW = 32'd11;
    #1;
    checks++;
    if (PA !== 32'd10) begin
      errors++;
      $display("FAIL rbw_before got %0d expected 10", PA);
    end
    tick();
    LE = 1'b0;
    checks++;
    if (PA !== 32'd11) begin
      errors++;
      $display("FAIL rbw_after got %0d expected 11", PA);
    end
  endtask

  task automatic test_reset_priority();
    RST = 1'b1; LE = 1'b1; RW = 4'd1; PW = 32'd55;
    RA = 4'd1; RB = 4'd14; RC = 4'd15;
    tick();
    RST = 1'b0;
    checks++;
    if (PA !== 32'd0) begin
      errors++;
      $display("FAIL rstpri_R1 got %0d expected 0", PA);
    end
    checks++;
    if (PB !== 32'd0) begin
      errors++;
      $display("FAIL rstpri_R14 got %0d expected 0", PB);
    end
    checks++;
    if (PC !== 32'd36) begin
      errors++;
      $display("FAIL rstpri_R15 got %0d expected 36", PC);
    end
    tick();
    LE = 1'b0;
    checks++;
    if (PA !== 32'd55) begin
      errors++;
      $display("FAIL rstpri_resume got %0d expected 55", PA);
    end
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_seq_fill();
    test_r15_write();
    test_le_low();
    test_read_before_write();
    test_reset_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_register_file
`default_nettype wire
